// File: rtl/bist_lfsr_ctrl.sv
// Sequencer for a single LFSR-based BIST run: clears and clocks the external pattern
// generator, compacts the CUT responses in a MISR and compares against a golden signature.
module bist_lfsr_ctrl #(
    parameter int unsigned      WIDTH         = 4,
    parameter int unsigned      PATTERN_COUNT = 15,
    parameter logic [WIDTH-1:0] MISR_TAPS     = WIDTH'(4'b1001),
    parameter logic [WIDTH-1:0] GOLDEN_SIG    = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] cut_resp,
    output logic             lfsr_en,
    output logic             lfsr_clr,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature
);

    localparam int unsigned      CNT_W    = $clog2(PATTERN_COUNT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PATTERN_COUNT - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INIT    = 3'd1;
    localparam logic [2:0] S_RUN     = 3'd2;
    localparam logic [2:0] S_COMPARE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] misr_q,  misr_d;
    logic             pass_q,  pass_d;

    logic             misr_fb;
    logic [WIDTH-1:0] misr_next;

    assign misr_fb   = ^(misr_q & MISR_TAPS);
    assign misr_next = {misr_q[WIDTH-2:0], misr_fb} ^ cut_resp;

    // NOTE: every always_comb output gets its hold value first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        misr_d  = misr_q;
        pass_d  = pass_q;
        if (abort) begin
            // Abort wins over everything; the MISR and counter keep their partial values.
            state_d = S_IDLE;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) state_d = S_INIT;
                end
                S_INIT: begin
                    misr_d  = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
                S_RUN: begin
                    misr_d = misr_next;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) state_d = S_COMPARE;
                end
                S_COMPARE: begin
                    pass_d  = (misr_q == GOLDEN_SIG);
                    state_d = S_DONE;
                end
                S_DONE: begin
                    if (start) begin
                        state_d = S_INIT;
                        pass_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    pass_d  = 1'b0;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            misr_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            misr_q  <= misr_d;
            pass_q  <= pass_d;
        end
    end

    assign lfsr_en   = (state_q == S_RUN);
    assign lfsr_clr  = (state_q == S_INIT);
    assign busy      = (state_q == S_INIT) || (state_q == S_RUN) || (state_q == S_COMPARE);
    assign done      = (state_q == S_DONE);
    assign pass      = pass_q;
    assign signature = misr_q;

endmodule
